noise_gen_multi: RTL

NOISE_GEN_MULTI -- requirements
Module: noise_gen_multi

---
 rtl/noise_gen_multi.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/noise_gen_multi.sv
// noise_gen_multi
//   Multi-channel pseudo-random noise source configured over a write-only
//   SPI (mode 0, MSB first, one 32-bit command per chip-select frame).
//   Each channel has a programmable clock divider that paces an LFSR. The
//   LFSR runs in either a long Fibonacci mode or a short 7-bit mode. Each
//   channel's noise output is the bit most recently shifted into its LFSR.
//
// Ports
//   sys_clk       in   sole clock, all state on the rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   spi_clock     in   SPI SCK (asynchronous to sys_clk)
//   spi_data      in   SPI MOSI
//   spi_cs        in   SPI chip select, active low, one command per frame
//   noise_signal  out  per-channel registered noise bit
//   cmd_ack       out  one-cycle pulse for each accepted command
//   frame_err     out  one-cycle pulse for each rejected frame
//
// Frame layout: [31:28] cmd, [27:24] channel, [23:0] payload
//   cmd 0  divider <= payload          (also clears the channel counter)
//   cmd 1  lfsr    <= payload or seed  (also clears the channel counter)
//   cmd 2  enable  <= payload[0], short <= payload[1]
//   cmd 3  clear the counters of all channels
module noise_gen_multi #(
  parameter int NUM_CH       = 4,
  parameter int LFSR_W       = 23,
  parameter int DIV_W        = 17,
  parameter int TAP_B        = 17,
  parameter int DEFAULT_DIV  = 53000,
  parameter int DEFAULT_SEED = 111
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clock,
  input  logic              spi_data,
  input  logic              spi_cs,
  output logic [NUM_CH-1:0] noise_signal,
  output logic              cmd_ack,
  output logic              frame_err
);

  localparam logic [LFSR_W-1:0] SEED    = LFSR_W'(DEFAULT_SEED);
  localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DEFAULT_DIV);

  // ---------------------------------------------------------------------
  // SPI front end
  // ---------------------------------------------------------------------
  logic [1:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sck_prev_q, sck_prev_d;
  logic        cs_prev_q, cs_prev_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        frame_err_q, frame_err_d;

  logic        sck_rise, cs_rise, cs_fall;
  logic [3:0]  cmd_f, ch_f;
  logic [23:0] payload;
  logic        cmd_valid, sync_all;
  logic        unused_bits;

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], spi_clock};
    cs_sync_d   = {cs_sync_q[0], spi_cs};
    mosi_sync_d = {mosi_sync_q[0], spi_data};
    sck_prev_d  = sck_sync_q[1];
    cs_prev_d   = cs_sync_q[1];

    sck_rise = sck_sync_q[1] & ~sck_prev_q;
    cs_rise  = cs_sync_q[1] & ~cs_prev_q;
    cs_fall  = ~cs_sync_q[1] & cs_prev_q;

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (cs_fall) begin
      bit_cnt_d = '0;
    end else if (!cs_sync_q[1] && sck_rise) begin
      shift_d = {shift_q[30:0], mosi_sync_q[1]};
      // Saturate so that long frames can never wrap back to 32.
      if (bit_cnt_q != 6'd33) bit_cnt_d = bit_cnt_q + 6'd1;
    end

    cmd_f   = shift_q[31:28];
    ch_f    = shift_q[27:24];
    payload = shift_q[23:0];

    cmd_valid   = cs_rise && (bit_cnt_q == 6'd32) && (cmd_f <= 4'd3) &&
                  (int'(ch_f) < NUM_CH);
    sync_all    = cmd_valid && (cmd_f == 4'd3);
    cmd_ack_d   = cmd_valid;
    frame_err_d = cs_rise && !cmd_valid;
  end

  // Payload bits above the divider/LFSR widths are intentionally ignored.
  assign unused_bits = ^payload;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cmd_ack_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_ack_q   <= cmd_ack_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Noise channels
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [NUM_CH-1:0]             en_q, en_d;
  logic [NUM_CH-1:0]             short_q, short_d;
  logic [NUM_CH-1:0]             noise_q, noise_d;
  logic [NUM_CH-1:0]             fb;

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    en_d    = en_q;
    short_d = short_q;
    noise_d = noise_q;
    fb      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fb[i] = short_q[i] ? (lfsr_q[i][6] ^ lfsr_q[i][5])
                         : (lfsr_q[i][LFSR_W-1] ^ lfsr_q[i][TAP_B]);
      // A command write takes priority over a tick in the same cycle.
      if (cmd_valid && (cmd_f != 4'd3) && (int'(ch_f) == i)) begin
        case (cmd_f)
          4'd0: begin
            div_d[i] = payload[DIV_W-1:0];
            cnt_d[i] = '0;
          end
          4'd1: begin
            lfsr_d[i] = (payload[LFSR_W-1:0] == '0) ? SEED : payload[LFSR_W-1:0];
            cnt_d[i]  = '0;
          end
          default: begin
            en_d[i]    = payload[0];
            short_d[i] = payload[1];
            if (!payload[0]) cnt_d[i] = '0;
          end
        endcase
      end else if (sync_all || !en_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= div_q[i]) begin
        cnt_d[i] = '0;
        // An all-zero register would lock up; reload instead of stepping.
        if (lfsr_q[i] == '0) begin
          lfsr_d[i] = SEED;
        end else begin
          lfsr_d[i]  = {lfsr_q[i][LFSR_W-2:0], fb[i]};
          noise_d[i] = fb[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q   <= {NUM_CH{DIV_RST}};
      cnt_q   <= '0;
      lfsr_q  <= {NUM_CH{SEED}};
      en_q    <= '1;
      short_q <= '0;
      noise_q <= '0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      en_q    <= en_d;
      short_q <= short_d;
      noise_q <= noise_d;
    end
  end

  assign noise_signal = noise_q;
  assign cmd_ack      = cmd_ack_q;
  assign frame_err    = frame_err_q;

endmodule
